dpsram_accum_ctrl: RTL

- Sequencer for the 128 x 13 dual-port SRAM (PF_DPSRAM_C0). It accumulates NAVG consecutive 128-bin frames of unsigned samples into the RAM by read-modify-write, then streams out the 128 sums with a valid/ready handshake.
- Port B is the read port and port A is the write port. Both share CLK.
- The RAM ports are driven directly by this block. Upstream is the per-bin sample stream; downstream is the packetiser.

---
 rtl/dpsram_accum_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dpsram_accum_ctrl.sv
// Read-modify-write accumulator for a 128-bin frame held in a dual-port SRAM,
// followed by a valid/ready readout of the accumulated bins.
module dpsram_accum_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 13,
    parameter int IN_W   = 8,
    parameter int NAVG_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [NAVG_W-1:0] cfg_navg,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              sat_flag,
    output logic [ADDR_W-1:0] ram_a_addr,
    output logic [DATA_W-1:0] ram_a_din,
    output logic              ram_a_wen,
    output logic [ADDR_W-1:0] ram_b_addr,
    input  logic [DATA_W-1:0] ram_b_dout,
    output logic [2:0]        o_dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACCUM    = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_RD_ADDR  = 3'd3;
    localparam logic [2:0] S_RD_DATA  = 3'd4;
    localparam logic [2:0] S_OUT_HOLD = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_BIN = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [NAVG_W-1:0] NAVG_ONE = NAVG_W'(1);
    localparam logic [DATA_W-1:0] SAT_MAX  = '1;

    logic [2:0]        r_state;
    logic [NAVG_W-1:0] r_navg;
    logic [NAVG_W-1:0] r_frame;
    logic [ADDR_W-1:0] r_bin;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_bin;
    logic [IN_W-1:0]   r_s1_data;
    logic              r_s1_first;

    logic [DATA_W-1:0] w_prev;
    logic [DATA_W:0]   w_sum_ext;
    logic              w_sat;
    logic [DATA_W-1:0] w_sum;

    // Handshakes: a sample moves when in_valid & in_ready at CLK; a readout
    // word moves when out_valid & out_ready at CLK, and is held until then.
    assign in_ready    = (r_state == S_ACCUM);
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    // The first frame ignores stale RAM contents, so no clear pass is needed.
    assign w_prev    = r_s1_first ? {DATA_W{1'b0}} : ram_b_dout;
    assign w_sum_ext = {1'b0, w_prev} + {{(DATA_W + 1 - IN_W){1'b0}}, r_s1_data};
    assign w_sat     = w_sum_ext[DATA_W];
    assign w_sum     = w_sat ? SAT_MAX : w_sum_ext[DATA_W-1:0];

    assign ram_a_wen  = r_s1_valid;
    assign ram_a_addr = r_s1_valid ? r_s1_bin : {ADDR_W{1'b0}};
    assign ram_a_din  = r_s1_valid ? w_sum : {DATA_W{1'b0}};

    always_comb begin
        ram_b_addr = {ADDR_W{1'b0}};
        if (r_state == S_ACCUM) begin
            ram_b_addr = r_bin;
        end else if (r_state == S_RD_ADDR) begin
            ram_b_addr = r_rd_ptr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_navg     <= '0;
            r_frame    <= '0;
            r_bin      <= '0;
            r_rd_ptr   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_bin   <= '0;
            r_s1_data  <= '0;
            r_s1_first <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            done       <= 1'b0;
            r_s1_valid <= 1'b0;
            if (r_s1_valid && w_sat) begin
                sat_flag <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_navg   <= (cfg_navg == '0) ? NAVG_ONE : cfg_navg;
                        r_frame  <= '0;
                        r_bin    <= '0;
                        sat_flag <= 1'b0;
                        r_state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        r_s1_valid <= 1'b1;
                        r_s1_bin   <= r_bin;
                        r_s1_data  <= in_data;
                        r_s1_first <= (r_frame == '0);
                        r_bin      <= r_bin + ADDR_ONE;
                        if (r_bin == LAST_BIN) begin
                            r_frame <= r_frame + NAVG_ONE;
                            if (r_frame == r_navg - NAVG_ONE) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    r_rd_ptr <= '0;
                    r_state  <= S_RD_ADDR;
                end
                S_RD_ADDR: begin
                    r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    out_data  <= ram_b_dout;
                    out_valid <= 1'b1;
                    out_last  <= (r_rd_ptr == LAST_BIN);
                    r_state   <= S_OUT_HOLD;
                end
                S_OUT_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (r_rd_ptr == LAST_BIN) begin
                            done    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + ADDR_ONE;
                            r_state  <= S_RD_ADDR;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
